// File: rtl/coin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : coin_pkg
// Desc     : Shared denomination codes, acceptor states and timer sizing for
//            the coin acceptor and the coin casher FSM.
// Revision : 1.0 - initial release
// ============================================================================
package coin_pkg;

    localparam logic [2:0] COIN_5C  = 3'b001;
    localparam logic [2:0] COIN_10C = 3'b010;
    localparam logic [2:0] COIN_25C = 3'b011;
    localparam logic [2:0] COIN_1D  = 3'b100;
    localparam logic [2:0] COIN_2D  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_AWAIT      = 3'd1,
        ST_REJECT     = 3'd2,
        ST_DUMP       = 3'd3,
        ST_RETURN_ON  = 3'd4,
        ST_RETURN_OFF = 3'd5
    } acc_state_t;

    // Bits needed for a counter that must reach max_count inclusive.
    function automatic int gate_timer_width(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_edge.sv
`default_nettype none
// ============================================================================
// Module   : debounce_edge
// Desc     : Synchronises a raw input, accepts a new level only after it has
//            been stable for DEBOUNCE_CYCLES, and flags filtered rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_edge
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int c_cnt_w = gate_timer_width(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], din};
            r_rise <= 1'b0;
            // Any return to the current level restarts the stability window.
            if (r_sync[1] != r_level) begin
                if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync[1];
                    r_rise  <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module   : coin_acceptor
// Desc     : Coin slot front-end for the casher FSM: debounces the sensors,
//            presents coins, drives reject/cashbox/return gates, tracks escrow.
//            Define COIN_AUDIT_EN to add accepted_total / rejected_total.
// Revision : 1.0 - initial release
// ============================================================================
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GATE_CYCLES     = 8,
    parameter int RESP_TIMEOUT    = 16,
    parameter int ESCROW_MAX      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sense,
    input  logic [2:0] coin_code,
    input  logic       return_btn,
    input  logic       wait_ready,
    input  logic       coin_reject,
    input  logic       eat_coins,
    input  logic       spit_coin,
    output logic       coin_insert,
    output logic [2:0] coin_type,
    output logic       return_coin,
    output logic       reject_gate,
    output logic       cashbox_gate,
    output logic       return_gate,
    output logic [3:0] escrow_count,
    output logic       busy
`ifdef COIN_AUDIT_EN
    ,
    output logic [15:0] accepted_total,
    output logic [15:0] rejected_total
`endif
);

    localparam int c_timer_max = (GATE_CYCLES > RESP_TIMEOUT) ? GATE_CYCLES : RESP_TIMEOUT;
    localparam int c_timer_w   = gate_timer_width(c_timer_max);
    localparam logic [c_timer_w-1:0] c_gate_last = c_timer_w'(GATE_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_resp_tmo  = c_timer_w'(RESP_TIMEOUT);
    localparam logic [c_timer_w-1:0] c_min_resp  = c_timer_w'(2);
    localparam logic [3:0]           c_esc_max   = 4'(ESCROW_MAX);

    acc_state_t             r_state;
    acc_state_t             w_state_nxt;
    logic [c_timer_w-1:0]   r_timer;
    logic [3:0]             r_escrow;
    logic                   r_coin_pend;
    logic [2:0]             r_pend_code;
    logic [2:0]             r_coin_type;
    logic                   r_coin_insert;
    logic                   r_spit_pend;
    logic                   r_eat_pend;

    logic w_coin_level, w_coin_rise, w_ret_level, w_ret_rise;
    logic w_unused_levels;
    logic w_coin_ev, w_has_esc, w_gate_done, w_spit_req, w_eat_req;
    logic w_spit_set, w_eat_set;
    logic w_insert, w_take_coin, w_esc_inc, w_esc_dec, w_esc_clr, w_spit_clr, w_eat_clr;
    logic w_esc_up;

    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin_db (
        .clk   (clk),
        .rst   (rst),
        .din   (coin_sense),
        .level (w_coin_level),
        .rise  (w_coin_rise)
    );

    debounce_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ret_db (
        .clk   (clk),
        .rst   (rst),
        .din   (return_btn),
        .level (w_ret_level),
        .rise  (w_ret_rise)
    );

    assign w_unused_levels = w_coin_level ^ w_ret_level;

    assign w_coin_ev   = w_coin_rise && !r_coin_pend;
    assign w_has_esc   = (r_escrow != 4'd0);
    assign w_gate_done = (r_timer == c_gate_last);
    assign w_spit_req  = spit_coin || r_spit_pend;
    assign w_eat_req   = eat_coins || r_eat_pend;
    assign w_esc_up    = w_esc_inc && (r_escrow < c_esc_max);

    // Spit during a return is absorbed by the return already under way.
    assign w_spit_set = spit_coin && (r_state == ST_REJECT || r_state == ST_DUMP);
    assign w_eat_set  = eat_coins && (r_state == ST_REJECT || r_state == ST_DUMP ||
                                      r_state == ST_RETURN_ON || r_state == ST_RETURN_OFF);

    always_comb begin
        w_state_nxt = r_state;
        w_insert    = 1'b0;
        w_take_coin = 1'b0;
        w_esc_inc   = 1'b0;
        w_esc_dec   = 1'b0;
        w_esc_clr   = 1'b0;
        w_spit_clr  = 1'b0;
        w_eat_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_has_esc) begin
                    w_spit_clr = 1'b1;
                    w_eat_clr  = 1'b1;
                end
                if (w_spit_req && w_has_esc) begin
                    w_spit_clr  = 1'b1;
                    w_state_nxt = ST_RETURN_ON;
                end else if (w_eat_req && w_has_esc) begin
                    w_eat_clr   = 1'b1;
                    w_state_nxt = ST_DUMP;
                end else if (r_coin_pend) begin
                    w_take_coin = 1'b1;
                    if (wait_ready && (r_escrow < c_esc_max)) begin
                        w_insert    = 1'b1;
                        w_state_nxt = ST_AWAIT;
                    end else begin
                        w_state_nxt = ST_REJECT;
                    end
                end
            end
            ST_AWAIT: begin
                if (coin_reject) begin
                    w_state_nxt = ST_REJECT;
                end else if (eat_coins) begin
                    w_esc_inc   = 1'b1;
                    w_state_nxt = ST_DUMP;
                end else if (wait_ready && (r_timer >= c_min_resp)) begin
                    w_esc_inc   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_timer == c_resp_tmo) begin
                    w_state_nxt = ST_REJECT;
                end
            end
            ST_REJECT: begin
                if (w_gate_done) w_state_nxt = ST_IDLE;
            end
            ST_DUMP: begin
                if (w_gate_done) begin
                    w_esc_clr   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RETURN_ON: begin
                if (w_gate_done) begin
                    w_esc_dec   = 1'b1;
                    w_state_nxt = ST_RETURN_OFF;
                end
            end
            ST_RETURN_OFF: begin
                if (w_gate_done) w_state_nxt = w_has_esc ? ST_RETURN_ON : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_coin_insert <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_coin_insert <= w_insert;
            if (r_state == ST_IDLE || w_state_nxt != r_state) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_timer_w'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_escrow    <= 4'd0;
            r_spit_pend <= 1'b0;
            r_eat_pend  <= 1'b0;
        end else begin
            if (w_esc_clr) begin
                r_escrow <= 4'd0;
            end else if (w_esc_up) begin
                r_escrow <= r_escrow + 4'd1;
            end else if (w_esc_dec && w_has_esc) begin
                r_escrow <= r_escrow - 4'd1;
            end
            r_spit_pend <= w_spit_clr ? 1'b0 : (r_spit_pend || w_spit_set);
            r_eat_pend  <= w_eat_clr  ? 1'b0 : (r_eat_pend  || w_eat_set);
        end
    end

    // coin_type must stay stable while a verdict is awaited, so an event that
    // lands during AWAIT is parked in r_pend_code and copied out at insert.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_coin_pend <= 1'b0;
            r_pend_code <= 3'd0;
            r_coin_type <= 3'd0;
        end else begin
            if (w_take_coin) begin
                r_coin_pend <= 1'b0;
            end else if (w_coin_ev) begin
                r_coin_pend <= 1'b1;
                r_pend_code <= coin_code;
            end
            if (w_coin_ev && r_state != ST_AWAIT) begin
                r_coin_type <= coin_code;
            end else if (w_insert) begin
                r_coin_type <= r_pend_code;
            end
        end
    end

`ifdef COIN_AUDIT_EN
    logic [15:0] r_accepted_total;
    logic [15:0] r_rejected_total;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_accepted_total <= 16'd0;
            r_rejected_total <= 16'd0;
        end else begin
            if (w_esc_up && r_accepted_total != 16'hFFFF) begin
                r_accepted_total <= r_accepted_total + 16'd1;
            end
            if (w_state_nxt == ST_REJECT && r_state != ST_REJECT &&
                r_rejected_total != 16'hFFFF) begin
                r_rejected_total <= r_rejected_total + 16'd1;
            end
        end
    end

    assign accepted_total = r_accepted_total;
    assign rejected_total = r_rejected_total;
`endif

    // Gates decode straight from state so a reset drops them on the same edge.
    assign coin_insert  = r_coin_insert;
    assign coin_type    = r_coin_type;
    assign return_coin  = w_ret_rise;
    assign reject_gate  = (r_state == ST_REJECT);
    assign cashbox_gate = (r_state == ST_DUMP);
    assign return_gate  = (r_state == ST_RETURN_ON);
    assign escrow_count = r_escrow;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
